// File: rtl/fp_pkg.sv
// Shared types and helpers for the fixed-point streaming stages.
package fp_pkg;

  typedef enum logic {ACCUM, DONE} acc_state_t;

  function automatic int fx_width(input int i, input int f);
    return i + f;
  endfunction

endpackage

// File: rtl/fp_sat_add.sv
// Combinational W-bit signed add that clamps to the representable range.
module fp_sat_add #(
  parameter int W = 19
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat_hit
);

  logic [W:0] full;

  // One guard bit: a disagreement between the top two bits means the true sum left the W-bit range.
  always_comb begin
    full    = {a[W-1], a} + {b[W-1], b};
    sat_hit = full[W] ^ full[W-1];
    if (!sat_hit)    sum = full[W-1:0];
    else if (full[W]) sum = {1'b1, {(W-1){1'b0}}};
    else              sum = {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/fp_stream_accum.sv
// Frame accumulator: sums N_TERMS fp_add results into a saturating accumulator, one result per frame.
module fp_stream_accum
  import fp_pkg::*;
#(
  parameter int I_IN    = 2,
  parameter int F_IN    = 13,
  parameter int I_ACC   = 6,
  parameter int F_ACC   = 13,
  parameter int N_TERMS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [I_IN+F_IN-1:0]   in_data,
  input  logic                   in_sign,
  input  logic                   in_ovf,
  input  logic                   in_unf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [I_ACC+F_ACC-1:0] out_data,
  output logic                   out_ovf,
  output logic                   out_unf
);

  localparam int W_IN  = fx_width(I_IN, F_IN);
  localparam int W_ACC = fx_width(I_ACC, F_ACC);
  localparam int W_EXT = fx_width(I_ACC, F_IN);
  localparam int CW    = $clog2(N_TERMS + 1);

  generate
    if (I_ACC < I_IN + 1) begin : g_bad_iacc
      $error("fp_stream_accum: I_ACC must be >= I_IN+1");
    end
    if (F_ACC < F_IN) begin : g_bad_facc
      $error("fp_stream_accum: F_ACC must be >= F_IN");
    end
    if (N_TERMS < 1) begin : g_bad_nterms
      $error("fp_stream_accum: N_TERMS must be >= 1");
    end
  endgenerate

  acc_state_t       state;
  logic [CW-1:0]    cnt;
  logic [W_ACC-1:0] acc;
  logic [W_EXT-1:0] ext_n;
  logic [W_ACC-1:0] ext_v;
  logic [W_ACC-1:0] sum;
  logic             sat_hit;
  logic             ovf, unf;

  // Widen integer part first, then align binary points; both steps are exact.
  always_comb begin
    ext_n = in_sign ? {{(I_ACC-I_IN){in_data[W_IN-1]}}, in_data}
                    : {{(I_ACC-I_IN){1'b0}}, in_data};
    ext_v = W_ACC'(ext_n) << (F_ACC - F_IN);
  end

  fp_sat_add #(.W(W_ACC)) u_sat_add (
    .a       (acc),
    .b       (ext_v),
    .sum     (sum),
    .sat_hit (sat_hit)
  );

  assign in_ready = !rst && (state == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= sum;
            ovf <= ovf | in_ovf | sat_hit;
            unf <= unf | in_unf;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N_TERMS - 1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // Result and flags hold until taken; the frame restarts clean on the same edge.
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign out_data = acc;
  assign out_ovf  = ovf;
  assign out_unf  = unf;

endmodule

// File: tb/tb_fp_stream_accum.sv
// Directed bench: default-parameter instance plus a narrow (I_ACC=4, N_TERMS=4) saturation instance.
module tb_fp_stream_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_sign, a_ovf_in, a_unf_in, a_ovalid, a_oready, a_ovf, a_unf;
  logic [14:0] a_data;
  logic [18:0] a_out;

  logic        s_valid, s_ready, s_sign, s_ovf_in, s_unf_in, s_ovalid, s_oready, s_ovf, s_unf;
  logic [14:0] s_data;
  logic [16:0] s_out;

  int n_vec = 0;
  int n_err = 0;

  fp_stream_accum u_dut (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data), .in_sign(a_sign),
    .in_ovf(a_ovf_in), .in_unf(a_unf_in),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_out),
    .out_ovf(a_ovf), .out_unf(a_unf)
  );

  fp_stream_accum #(.I_ACC(4), .N_TERMS(4)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data), .in_sign(s_sign),
    .in_ovf(s_ovf_in), .in_unf(s_unf_in),
    .out_valid(s_ovalid), .out_ready(s_oready), .out_data(s_out),
    .out_ovf(s_ovf), .out_unf(s_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_frame(input logic [14:0] d, input logic sg, input int unf_beat, input int ovf_beat);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("a_rdy", 32'(a_ready), 32'd1);
      chk("a_busy", 32'(a_ovalid), 32'd0);
      a_valid = 1'b1; a_data = d; a_sign = sg;
      a_unf_in = (i == unf_beat); a_ovf_in = (i == ovf_beat);
      @(posedge clk);
    end
    @(negedge clk);
    a_valid = 1'b0; a_unf_in = 1'b0; a_ovf_in = 1'b0;
    chk("a_lat", 32'(a_ovalid), 32'd1);
    chk("a_rdy_done", 32'(a_ready), 32'd0);
  endtask

  task automatic a_take();
    @(negedge clk);
    a_oready = 1'b1;
    @(negedge clk);
    a_oready = 1'b0;
    chk("a_take_vld", 32'(a_ovalid), 32'd0);
    chk("a_take_acc", 32'(a_out), 32'd0);
  endtask

  task automatic s_frame(input logic [14:0] d, input logic sg);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s_rdy", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_data = d; s_sign = sg;
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("s_lat", 32'(s_ovalid), 32'd1);
  endtask

  task automatic s_take();
    @(negedge clk);
    s_oready = 1'b1;
    @(negedge clk);
    s_oready = 1'b0;
    chk("s_take_vld", 32'(s_ovalid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    {a_valid, a_sign, a_ovf_in, a_unf_in, a_oready} = '0;
    {s_valid, s_sign, s_ovf_in, s_unf_in, s_oready} = '0;
    a_data = '0; s_data = '0;
    #12;
    chk("rst_rdy", 32'(a_ready), 32'd0);
    chk("rst_vld", 32'(a_ovalid), 32'd0);
    chk("rst_data", 32'(a_out), 32'd0);
    chk("rst_flags", {30'd0, a_ovf, a_unf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_rdy", 32'(a_ready), 32'd1);

    // unsigned 8 x 1.0
    a_frame(15'h2000, 1'b0, -1, -1);
    chk("uns_data", 32'(a_out), 32'h10000);
    chk("uns_flags", {30'd0, a_ovf, a_unf}, 32'd0);
    a_take();

    // signed 8 x -1.0
    a_frame(15'h6000, 1'b1, -1, -1);
    chk("sgn_data", 32'(a_out), 32'h70000);
    chk("sgn_flags", {30'd0, a_ovf, a_unf}, 32'd0);
    a_take();

    // positive clamp, then negative sum landing exactly on the minimum
    s_frame(15'h7FFF, 1'b0);
    chk("sat_pos_data", 32'(s_out), 32'h0FFFF);
    chk("sat_pos_ovf", 32'(s_ovf), 32'd1);
    chk("sat_pos_unf", 32'(s_unf), 32'd0);
    s_take();
    s_frame(15'h4000, 1'b1);
    chk("sat_neg_data", 32'(s_out), 32'h10000);
    chk("sat_neg_ovf", 32'(s_ovf), 32'd0);
    s_take();

    // backpressure with in_valid held high; frame carries in_ovf on beat 6
    a_frame(15'h2000, 1'b0, -1, 5);
    a_valid = 1'b1; a_data = 15'h7FFF; a_sign = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", 32'(a_ovalid), 32'd1);
      chk("bp_rdy", 32'(a_ready), 32'd0);
      chk("bp_data", 32'(a_out), 32'h10000);
      chk("bp_flags", {30'd0, a_ovf, a_unf}, 32'h2);
    end
    a_valid = 1'b0;
    a_take();
    a_frame(15'h2000, 1'b0, -1, -1);
    chk("bp_next_data", 32'(a_out), 32'h10000);
    chk("bp_next_flags", {30'd0, a_ovf, a_unf}, 32'd0);
    a_take();

    // sticky underflow for one frame only
    a_frame(15'h2000, 1'b0, 2, -1);
    chk("unf_set", 32'(a_unf), 32'd1);
    chk("unf_data", 32'(a_out), 32'h10000);
    a_take();
    a_frame(15'h2000, 1'b0, -1, -1);
    chk("unf_clr", 32'(a_unf), 32'd0);
    a_take();

    // reset after 3 beats discards the partial frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_data = 15'h2000; a_sign = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    chk("mid_partial", 32'(a_out), 32'h6000);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(a_out), 32'd0);
    chk("mid_rst_rdy", 32'(a_ready), 32'd0);
    chk("mid_rst_vld", 32'(a_ovalid), 32'd0);
    @(negedge clk);
    chk("mid_rst_hold", 32'(a_out), 32'd0);
    rst = 1'b0;
    a_valid = 1'b0;
    a_frame(15'h2000, 1'b0, -1, -1);
    chk("mid_fresh", 32'(a_out), 32'h10000);
    a_take();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
